barrel_shift_pipe: RTL and testbench



---
 rtl/barrel_shift_pipe.sv | 114 +++++++++++
 tb/tb_barrel_shift_pipe.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_shift_pipe.sv
// Two-stage 8-bit shift unit: stage 1 rotates and captures carry-out,
// stage 2 applies the fill mask for SLL/SRL/SRA (ROR passes through).
module barrel_shift_pipe (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] d_in,
    input  logic [2:0] sh_amt,
    input  logic [1:0] op,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] d_out,
    output logic       carry,
    output logic       zero
);
    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    logic       r_s1_valid;
    logic [7:0] r_s1_rot;
    logic [2:0] r_s1_amt;
    logic [1:0] r_s1_op;
    logic       r_s1_sign;
    logic       r_s1_carry;

    logic       r_out_valid;
    logic [7:0] r_d_out;
    logic       r_carry;
    logic       r_zero;

    logic       w_s2_adv;
    logic       w_s1_adv;
    logic       w_left;
    logic [7:0] w_rot1;
    logic [7:0] w_rot2;
    logic [7:0] w_rot4;
    logic [2:0] w_cidx;
    logic       w_carry1;
    logic [7:0] w_mask_r;
    logic [7:0] w_mask_l;
    logic [7:0] w_mask;
    logic       w_fill;
    logic [7:0] w_res;

    assign w_s2_adv = !r_out_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;

    // Stage 1: log rotator, left for SLL and right for everything else.
    assign w_left = (op == OP_SLL);
    assign w_rot1 = sh_amt[0] ? (w_left ? {d_in[6:0], d_in[7]} : {d_in[0], d_in[7:1]}) : d_in;
    assign w_rot2 = sh_amt[1] ? (w_left ? {w_rot1[5:0], w_rot1[7:6]} : {w_rot1[1:0], w_rot1[7:2]}) : w_rot1;
    assign w_rot4 = sh_amt[2] ? {w_rot2[3:0], w_rot2[7:4]} : w_rot2;

    assign w_cidx   = w_left ? 3'(4'd8 - {1'b0, sh_amt}) : (sh_amt - 3'd1);
    assign w_carry1 = (sh_amt != 3'd0) && d_in[w_cidx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_rot   <= 8'h00;
            r_s1_amt   <= 3'd0;
            r_s1_op    <= 2'b00;
            r_s1_sign  <= 1'b0;
            r_s1_carry <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_rot   <= w_rot4;
                r_s1_amt   <= sh_amt;
                r_s1_op    <= op;
                r_s1_sign  <= d_in[7];
                r_s1_carry <= w_carry1;
            end
        end
    end

    // Right-shift mask covers the top sh_amt bits; SLL uses its bit reversal.
    assign w_mask_r = ~(8'hFF >> r_s1_amt);

    always_comb begin
        w_mask_l = 8'h00;
        for (int i = 0; i < 8; i++)
            w_mask_l[i] = w_mask_r[7-i];
    end

    assign w_mask = (r_s1_op == OP_SLL) ? w_mask_l : w_mask_r;
    assign w_fill = (r_s1_op == OP_SRA) && r_s1_sign;
    assign w_res  = (r_s1_op == OP_ROR) ? r_s1_rot
                  : ((r_s1_rot & ~w_mask) | (w_fill ? w_mask : 8'h00));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_d_out     <= 8'h00;
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_d_out <= w_res;
                r_carry <= r_s1_carry;
                r_zero  <= (w_res == 8'h00);
            end
        end
    end

    assign in_ready  = w_s1_adv;
    assign out_valid = r_out_valid;
    assign d_out     = r_d_out;
    assign carry     = r_carry;
    assign zero      = r_zero;
endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Self-checking bench for barrel_shift_pipe: directed vectors, streaming,
// backpressure, random traffic against a queue-based reference model, reset.
module tb_barrel_shift_pipe;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] d_in = 8'h00;
    logic [2:0] sh_amt = 3'd0;
    logic [1:0] op = 2'b00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] d_out;
    logic       carry;
    logic       zero;

    int total = 0;
    int bad   = 0;

    barrel_shift_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .d_in(d_in), .sh_amt(sh_amt), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .d_out(d_out), .carry(carry), .zero(zero)
    );

    always #5 clk = ~clk;

    // Reference: shift as plain arithmetic on a widened word; returns {carry, zero, result}.
    function automatic logic [9:0] model(input logic [7:0] d, input logic [2:0] a, input logic [1:0] o);
        logic [15:0]        t;
        logic signed [15:0] ts;
        logic [7:0]         res;
        logic               c;
        t  = {d, 8'h00} >> a;
        c  = t[7];
        case (o)
            2'b00: begin
                t   = {8'h00, d} << a;
                res = t[7:0];
                c   = (a != 3'd0) ? t[8] : 1'b0;
            end
            2'b01: res = t[15:8];
            2'b10: begin
                ts  = {d, 8'h00};
                ts  = ts >>> a;
                res = ts[15:8];
            end
            default: begin
                t   = {d, d} >> a;
                res = t[7:0];
            end
        endcase
        return {c, (res == 8'h00), res};
    endfunction

    task automatic step(input logic iv, input logic [7:0] d, input logic [2:0] a,
                        input logic [1:0] o, input logic ordy);
        @(negedge clk);
        in_valid  = iv;
        d_in      = d;
        sh_amt    = a;
        op        = o;
        out_ready = ordy;
        #1;
    endtask

    // Sends one operand into an idle pipe and reports the edges until its output transfer.
    task automatic send_and_wait(input logic [7:0] d, input logic [2:0] a, input logic [1:0] o,
                                 output logic [9:0] got, output int lat, output logic acc);
        step(1'b1, d, a, o, 1'b1);
        acc = in_ready;
        lat = 0;
        got = 10'h000;
        while (lat < 8) begin
            step(1'b0, 8'h00, 3'd0, 2'b00, 1'b1);
            lat++;
            if (out_valid) begin
                got = {carry, zero, d_out};
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total++;
        if ({out_valid, d_out, carry, zero} !== 11'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", {out_valid, d_out, carry, zero});
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [7:0] dv [11] = '{8'h96, 8'h96, 8'h96, 8'h96, 8'h76, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h05, 8'h80};
        logic [2:0] av [11] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd1};
        logic [1:0] ov [11] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd0};
        logic [9:0] ev [11] = '{{2'b00, 8'hB0}, {2'b10, 8'h12}, {2'b10, 8'hF2}, {2'b10, 8'hD2},
                                {2'b11, 8'h00}, {2'b00, 8'hA5}, {2'b00, 8'hA5}, {2'b00, 8'hA5},
                                {2'b00, 8'hA5}, {2'b11, 8'h00}, {2'b11, 8'h00}};
        logic [9:0] got;
        int         lat;
        logic       acc;
        for (int i = 0; i < 11; i++) begin
            send_and_wait(dv[i], av[i], ov[i], got, lat, acc);
            total++;
            if (got !== ev[i] || lat != 2 || acc !== 1'b1) begin
                bad++;
                $display("FAIL directed_%0d {c,z,d} got=%h lat=%0d acc=%b want=%h lat=2 acc=1",
                         i, got, lat, acc, ev[i]);
            end
        end
    endtask

    task automatic test_stream();
        logic [9:0] q[$];
        logic [7:0] d;
        logic [2:0] a;
        logic [1:0] o;
        int         first = -1;
        int         last  = -1;
        int         n     = 0;
        logic       gaps  = 1'b0;
        for (int c = 0; c < 14; c++) begin
            d = 8'($urandom);
            a = 3'($urandom);
            o = 2'($urandom);
            step(c < 8, d, a, o, 1'b1);
            if (out_valid && out_ready) begin
                if (first < 0) first = c;
                else if (c != last + 1) gaps = 1'b1;
                last = c;
                n++;
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL stream_extra got=%h want=none", {carry, zero, d_out});
                end else begin
                    if ({carry, zero, d_out} !== q[0]) begin
                        bad++;
                        $display("FAIL stream_data got=%h want=%h", {carry, zero, d_out}, q[0]);
                    end
                    void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) q.push_back(model(d, a, o));
            if (c < 8) begin
                total++;
                if (in_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL stream_in_ready cyc=%0d got=%b want=1", c, in_ready);
                end
            end
        end
        total++;
        if (n != 8 || first != 2 || gaps) begin
            bad++;
            $display("FAIL stream_timing got n=%0d first=%0d gaps=%b want n=8 first=2 gaps=0",
                     n, first, gaps);
        end
    endtask

    task automatic test_backpressure();
        logic [9:0] q[$];
        logic [7:0] d;
        logic [2:0] a;
        logic [1:0] o;
        logic [9:0] held = 10'h000;
        int         acc_low = 0;
        int         n = 0;
        for (int c = 0; c < 20; c++) begin
            d = 8'($urandom);
            a = 3'($urandom);
            o = 2'($urandom);
            step(c < 12, d, a, o, c >= 5);
            if (c == 2) held = {carry, zero, d_out};
            if (c == 3 || c == 4) begin
                total++;
                if ({carry, zero, d_out} !== held || out_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL bp_hold cyc=%0d got=%h v=%b want=%h v=1",
                             c, {carry, zero, d_out}, out_valid, held);
                end
            end
            if (c >= 2 && c <= 4) begin
                total++;
                if (in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL bp_in_ready_low cyc=%0d got=%b want=0", c, in_ready);
                end
            end
            if (c == 5) begin
                total++;
                if (in_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL bp_in_ready_release got=%b want=1", in_ready);
                end
            end
            if (c < 5 && in_valid && in_ready) acc_low++;
            if (out_valid && out_ready) begin
                n++;
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL bp_extra got=%h want=none", {carry, zero, d_out});
                end else begin
                    if ({carry, zero, d_out} !== q[0]) begin
                        bad++;
                        $display("FAIL bp_data got=%h want=%h", {carry, zero, d_out}, q[0]);
                    end
                    void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) q.push_back(model(d, a, o));
        end
        total++;
        if (acc_low != 2 || q.size() != 0 || n != 9) begin
            bad++;
            $display("FAIL bp_counts got acc_low=%0d left=%0d n=%0d want acc_low=2 left=0 n=9",
                     acc_low, q.size(), n);
        end
    endtask

    task automatic test_random();
        logic [9:0] q[$];
        logic [7:0] d;
        logic [2:0] a;
        logic [1:0] o;
        logic       stalled = 1'b0;
        logic [9:0] prev = 10'h000;
        for (int c = 0; c < 320; c++) begin
            d = 8'($urandom);
            a = 3'($urandom);
            o = 2'($urandom);
            step((c < 300) && ($urandom_range(3) != 0), d, a, o, (c >= 300) || ($urandom_range(2) != 0));
            if (stalled) begin
                total++;
                if ({carry, zero, d_out} !== prev || out_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL rand_hold cyc=%0d got=%h want=%h", c, {carry, zero, d_out}, prev);
                end
            end
            stalled = out_valid && !out_ready;
            prev    = {carry, zero, d_out};
            if (out_valid && out_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL rand_extra got=%h want=none", {carry, zero, d_out});
                end else begin
                    if ({carry, zero, d_out} !== q[0]) begin
                        bad++;
                        $display("FAIL rand_data got=%h want=%h", {carry, zero, d_out}, q[0]);
                    end
                    void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) q.push_back(model(d, a, o));
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL rand_drain got left=%0d want 0", q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] got;
        int         lat;
        logic       acc;
        step(1'b1, 8'h96, 3'd3, 2'd2, 1'b0);
        step(1'b1, 8'h5A, 3'd1, 2'd0, 1'b0);
        step(1'b0, 8'h00, 3'd0, 2'd0, 1'b0);
        total++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || d_out !== 8'hF2) begin
            bad++;
            $display("FAIL rmid_full got v=%b rdy=%b d=%h want v=1 rdy=0 d=f2", out_valid, in_ready, d_out);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, d_out, carry, zero} !== 11'h0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rmid_reset got=%h rdy=%b want=0 rdy=1", {out_valid, d_out, carry, zero}, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_and_wait(8'h01, 3'd1, 2'd0, got, lat, acc);
        total++;
        if (got !== {2'b00, 8'h02} || lat != 2 || acc !== 1'b1) begin
            bad++;
            $display("FAIL rmid_after got=%h lat=%0d acc=%b want=002 lat=2 acc=1", got, lat, acc);
        end
        step(1'b0, 8'h00, 3'd0, 2'd0, 1'b1);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rmid_no_stale got v=%b want 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stream();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
